// File: rtl/ripple_count_capture_pkg.sv
// Shared FSM state encoding and default widths for the ripple counter capture block.
// No logic; no latency; no backpressure.
package ripple_count_capture_pkg;

  localparam int CNT_W_DEF      = 4;
  localparam int ACC_W_DEF      = 16;
  localparam int WIN_W_DEF      = 16;
  localparam int STABLE_CYC_DEF = 2;
  localparam bit DOWN_DEF       = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

endpackage

// File: rtl/ripple_count_capture_async_bus_filter.sv
// 2-flop synchroniser plus hold-off filter for a skewed asynchronous bus; accepts a value
// 2 + STABLE_CYC cycles after it settles. Free-running, no backpressure.
module async_bus_filter #(
  parameter int W          = 4,
  parameter int STABLE_CYC = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] din,
  output logic [W-1:0] stable_val,
  output logic         stable_ok
);

  localparam int CW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);

  logic [W-1:0]  sync1;
  logic [W-1:0]  sync_val;
  logic [W-1:0]  prev;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] run_cnt_nxt;

  // Run length saturates at STABLE_CYC so an accepted value keeps being re-confirmed.
  always_comb begin
    run_cnt_nxt = run_cnt;
    if (sync_val == prev) begin
      if (run_cnt < CW'(STABLE_CYC))
        run_cnt_nxt = run_cnt + 1'b1;
    end else begin
      run_cnt_nxt = CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= '0;
      sync_val   <= '0;
      prev       <= '0;
      run_cnt    <= '0;
      stable_val <= '0;
      stable_ok  <= 1'b0;
    end else begin
      sync1    <= din;
      sync_val <= sync1;
      prev     <= sync_val;
      run_cnt  <= run_cnt_nxt;
      if (run_cnt_nxt == CW'(STABLE_CYC)) begin
        stable_val <= sync_val;
        stable_ok  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/ripple_count_capture.sv
// Counts ripple-counter edges over a window of win_len cycles after arming; result appears
// win_len+1 cycles after start once the input is stable, held until res_ready.
module ripple_count_capture
  import ripple_count_capture_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int ACC_W      = ACC_W_DEF,
  parameter int WIN_W      = WIN_W_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter bit DOWN       = DOWN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] res_count,
  output logic             res_ovf
);

  localparam int SUM_W = ((ACC_W > CNT_W) ? ACC_W : CNT_W) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] stable_val;
  logic             stable_ok;
  logic [CNT_W-1:0] base;
  logic [CNT_W-1:0] delta;
  logic [WIN_W-1:0] wcnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [SUM_W-1:0] sum;
  logic             sat;
  logic             ovf;

  async_bus_filter #(
    .W          (CNT_W),
    .STABLE_CYC (STABLE_CYC)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .din        (cnt_in),
    .stable_val (stable_val),
    .stable_ok  (stable_ok)
  );

  // Delta is zero whenever stable_val has not moved since the last cycle, so it is
  // simply folded into the accumulator every MEASURE cycle.
  always_comb begin
    delta   = DOWN ? (base - stable_val) : (stable_val - base);
    sum     = SUM_W'(acc) + SUM_W'(delta);
    sat     = (sum > SUM_W'(ACC_MAX));
    acc_nxt = sat ? ACC_MAX : sum[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      res_ovf   <= 1'b0;
      base      <= '0;
      wcnt      <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wcnt  <= (win_len == '0) ? WIN_W'(1) : win_len;
            acc   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= ARM;
          end
        end
        ARM: begin
          if (stable_ok) begin
            base  <= stable_val;
            state <= MEASURE;
          end
        end
        MEASURE: begin
          acc  <= acc_nxt;
          ovf  <= ovf | sat;
          base <= stable_val;
          wcnt <= wcnt - 1'b1;
          if (wcnt == WIN_W'(1)) begin
            res_valid <= 1'b1;
            res_count <= acc_nxt;
            res_ovf   <= ovf | sat;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
